// File: rtl/bg_pixel_gen.sv
// Background pixel generator: fetches one 240-pixel ROM line per window line during
// horizontal blanking and paints it into a fixed window, outputs registered one clk late.
//
// state  | meaning
// IDLE   | waiting for a vs rise / de fall that starts a window line
// ADDR   | drive rom_addr with the line offset into the window
// WAIT   | hold rom_addr while the ROM produces the line
// LOAD   | capture rom_rd_data into row_buf (skipped if the line already started)
module bg_pixel_gen #(
    parameter int          WIN_X0 = 40,
    parameter int          WIN_Y0 = 12,
    parameter int          WIN_H  = 256,
    parameter logic [23:0] FG_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB = 24'h000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         de_in,
    input  logic         hs_in,
    input  logic         vs_in,
    input  logic         grid_en,
    output logic [7:0]   rom_addr,
    input  logic [239:0] rom_rd_data,
    output logic [23:0]  rgb_out,
    output logic         de_out,
    output logic         hs_out,
    output logic         vs_out,
    output logic         in_win
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_LOAD} state_t;

    localparam logic [12:0] X_LO = 13'(WIN_X0);
    localparam logic [12:0] X_HI = 13'(WIN_X0 + 239);
    localparam logic [12:0] Y_LO = 13'(WIN_Y0);
    localparam logic [12:0] Y_HI = 13'(WIN_Y0 + WIN_H - 1);

    state_t         state_q, state_d;
    logic           vs_prev_q, de_prev_q, armed_q, armed_d;
    logic [11:0]    col_cnt_q, col_cnt_d;
    logic [11:0]    line_cnt_q, line_cnt_d;
    logic [7:0]     rom_addr_q, rom_addr_d;
    logic [239:0]   row_buf_q, row_buf_d;
    logic [23:0]    rgb_q, rgb_d;
    logic           de_q, hs_q, vs_q, in_win_q, in_win_d;

    logic           vs_rise, de_fall, next_in_win, fetch_trig;
    logic           line_win, col_win, pix_bit;
    logic [7:0]     col_off, bit_idx;

    always_comb begin
        vs_rise = vs_in & ~vs_prev_q;
        de_fall = ~de_in & de_prev_q;
        col_cnt_d = de_in ? col_cnt_q + 12'd1 : 12'd0;
        line_cnt_d = line_cnt_q;
        if (vs_rise) begin
            line_cnt_d = 12'd0;
        end else if (de_fall && line_cnt_q != 12'hFFF) begin
            line_cnt_d = line_cnt_q + 12'd1;
        end
        next_in_win = ({1'b0, line_cnt_d} >= Y_LO) && ({1'b0, line_cnt_d} <= Y_HI);
        // Fetches stay disabled after reset until a frame start has been seen.
        armed_d    = armed_q | vs_rise;
        fetch_trig = (vs_rise | de_fall) & armed_d & next_in_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fetch_trig) state_d = S_ADDR;
            S_ADDR:  state_d = S_WAIT;
            S_WAIT:  state_d = S_LOAD;
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        row_buf_d  = row_buf_q;
        if (state_q == S_ADDR) begin
            rom_addr_d = line_cnt_q[7:0] - 8'(WIN_Y0);
        end
        // A line that began during the fetch keeps showing the old row.
        if (state_q == S_LOAD && !de_in) begin
            row_buf_d = rom_rd_data;
        end
    end

    always_comb begin
        line_win = ({1'b0, line_cnt_q} >= Y_LO) && ({1'b0, line_cnt_q} <= Y_HI);
        col_win  = ({1'b0, col_cnt_q} >= X_LO) && ({1'b0, col_cnt_q} <= X_HI);
        in_win_d = de_in & line_win & col_win;
        col_off  = col_cnt_q[7:0] - 8'(WIN_X0);
        bit_idx  = 8'd239 - col_off;
        pix_bit  = row_buf_q[bit_idx];
        if (!de_in) begin
            rgb_d = 24'h0;
        end else if (grid_en && in_win_d && pix_bit) begin
            rgb_d = FG_RGB;
        end else begin
            rgb_d = BG_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            col_cnt_q  <= 12'd0;
            line_cnt_q <= 12'd0;
            rom_addr_q <= 8'd0;
            row_buf_q  <= '0;
            rgb_q      <= 24'h0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            in_win_q   <= 1'b0;
        end else begin
            vs_prev_q  <= vs_in;
            de_prev_q  <= de_in;
            armed_q    <= armed_d;
            col_cnt_q  <= col_cnt_d;
            line_cnt_q <= line_cnt_d;
            rom_addr_q <= rom_addr_d;
            row_buf_q  <= row_buf_d;
            rgb_q      <= rgb_d;
            de_q       <= de_in;
            hs_q       <= hs_in;
            vs_q       <= vs_in;
            in_win_q   <= in_win_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rgb_out  = rgb_q;
    assign de_out   = de_q;
    assign hs_out   = hs_q;
    assign vs_out   = vs_q;
    assign in_win   = in_win_q;

endmodule
